// File: rtl/qsys_sysid_ext_if.sv
// Bus bundle for the system-identification slave: word address, read/write
// strobes, byte-lane write data and the pipelined read-return pair.
interface qsys_sysid_ext_if;
   logic [2:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata;
   logic        readdatavalid;

   modport slave (
      input  address,
      input  read,
      input  write,
      input  writedata,
      input  byteenable,
      output readdata,
      output readdatavalid
   );

   modport master (
      output address,
      output read,
      output write,
      output writedata,
      output byteenable,
      input  readdata,
      input  readdatavalid
   );
endinterface

// File: rtl/qsys_sysid_ext.sv
// System-identification slave: ID/timestamp words, 64-bit uptime with coherent
// high-word snapshot, prescaled seconds counter, scratch and capability words.
module qsys_sysid_ext #(
   parameter logic [31:0] SYS_ID       = 32'h0000_0000,
   parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
   parameter logic [31:0] CLK_HZ       = 32'd50_000_000,
   parameter int          READ_LATENCY = 1,
   parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000
) (
   input  logic             clock,
   input  logic             reset,
   qsys_sysid_ext_if.slave  bus
);

   localparam logic [1:0]  LAT_BITS  = 2'(READ_LATENCY);
   localparam logic [31:0] CAPS_WORD = {16'h0001, 6'b00_0000, LAT_BITS, 8'h00};

   localparam logic [2:0] A_ID      = 3'd0;
   localparam logic [2:0] A_TS      = 3'd1;
   localparam logic [2:0] A_UP_LO   = 3'd2;
   localparam logic [2:0] A_UP_HI   = 3'd3;
   localparam logic [2:0] A_SECONDS = 3'd4;
   localparam logic [2:0] A_SCRATCH = 3'd5;
   localparam logic [2:0] A_CAPS    = 3'd6;

   logic [63:0] r_uptime;
   logic [31:0] r_up_shadow;
   logic [31:0] r_prescale;
   logic [31:0] r_seconds;
   logic [31:0] r_scratch;

   logic [READ_LATENCY-1:0] r_pipe_vld;
   logic [31:0]             r_pipe_data [READ_LATENCY];

   logic        w_tc;
   logic        w_wr_seconds;
   logic        w_wr_scratch;
   logic        w_rd_up_lo;
   logic [31:0] w_rd_mux;
   logic [31:0] w_rd_data;

   function automatic logic [31:0] f_byte_merge(input logic [31:0] old_d,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  be);
      logic [31:0] res;
      res = old_d;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) begin
            res[8*b +: 8] = wdata[8*b +: 8];
         end else begin
            res[8*b +: 8] = old_d[8*b +: 8];
         end
      end
      return res;
   endfunction

   assign w_tc         = (r_prescale == (CLK_HZ - 32'd1));
   assign w_wr_seconds = bus.write && (bus.address == A_SECONDS);
   assign w_wr_scratch = bus.write && (bus.address == A_SCRATCH);
   assign w_rd_up_lo   = bus.read  && (bus.address == A_UP_LO);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_uptime <= 64'd0;
      end else begin
         r_uptime <= r_uptime + 64'd1;
      end
   end

   // The high word is captured with the same pre-edge uptime the UP_LO read returns.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_up_shadow <= 32'd0;
      end else if (w_rd_up_lo) begin
         r_up_shadow <= r_uptime[63:32];
      end else begin
         r_up_shadow <= r_up_shadow;
      end
   end

   // A software clear takes priority over a coincident terminal count.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_prescale <= 32'd0;
         r_seconds  <= 32'd0;
      end else if (w_wr_seconds) begin
         r_prescale <= 32'd0;
         r_seconds  <= 32'd0;
      end else if (w_tc) begin
         r_prescale <= 32'd0;
         r_seconds  <= r_seconds + 32'd1;
      end else begin
         r_prescale <= r_prescale + 32'd1;
         r_seconds  <= r_seconds;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_scratch <= SCRATCH_INIT;
      end else if (w_wr_scratch) begin
         r_scratch <= f_byte_merge(r_scratch, bus.writedata, bus.byteenable);
      end else begin
         r_scratch <= r_scratch;
      end
   end

   always_comb begin
      w_rd_mux = 32'd0;
      case (bus.address)
         A_ID:      w_rd_mux = SYS_ID;
         A_TS:      w_rd_mux = TIMESTAMP;
         A_UP_LO:   w_rd_mux = r_uptime[31:0];
         A_UP_HI:   w_rd_mux = r_up_shadow;
         A_SECONDS: w_rd_mux = r_seconds;
         A_SCRATCH: w_rd_mux = r_scratch;
         A_CAPS:    w_rd_mux = CAPS_WORD;
         default:   w_rd_mux = 32'd0;
      endcase
   end

   // Idle stages carry zero data so readdata is 0 whenever valid is low.
   always_comb begin
      w_rd_data = 32'd0;
      if (bus.read) begin
         w_rd_data = w_rd_mux;
      end else begin
         w_rd_data = 32'd0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            r_pipe_vld[i]  <= 1'b0;
            r_pipe_data[i] <= 32'd0;
         end
      end else begin
         r_pipe_vld[0]  <= bus.read;
         r_pipe_data[0] <= w_rd_data;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_pipe_vld[i]  <= r_pipe_vld[i-1];
            r_pipe_data[i] <= r_pipe_data[i-1];
         end
      end
   end

   assign bus.readdata      = r_pipe_data[READ_LATENCY-1];
   assign bus.readdatavalid = r_pipe_vld[READ_LATENCY-1];

endmodule

// File: tb/tb_qsys_sysid_ext.sv
// Directed bench: DUT A (latency 2, CLK_HZ 10) covers register map, snapshot,
// seconds and scratch; DUT B (latency 3) covers latency and reset mid-read.
module tb_qsys_sysid_ext;

   logic clk;
   logic rst_a;
   logic rst_b;
   int   n_pass;
   int   n_total;

   qsys_sysid_ext_if bus_a ();
   qsys_sysid_ext_if bus_b ();

   qsys_sysid_ext #(
      .SYS_ID       (32'h5799_0A3F),
      .TIMESTAMP    (32'h1234_5678),
      .CLK_HZ       (32'd10),
      .READ_LATENCY (2),
      .SCRATCH_INIT (32'h0000_0000)
   ) dut_a (
      .clock (clk),
      .reset (rst_a),
      .bus   (bus_a.slave)
   );

   qsys_sysid_ext #(
      .SYS_ID       (32'h5799_0A3F),
      .TIMESTAMP    (32'h1234_5678),
      .CLK_HZ       (32'd10),
      .READ_LATENCY (3),
      .SCRATCH_INIT (32'h0000_0000)
   ) dut_b (
      .clock (clk),
      .reset (rst_b),
      .bus   (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic chk_a(input string tag, input logic vld, input logic [31:0] data);
      chk({tag, "_vld"}, {31'd0, bus_a.readdatavalid}, {31'd0, vld});
      chk({tag, "_data"}, bus_a.readdata, data);
   endtask

   task automatic rd_a(input logic [2:0] addr);
      bus_a.read    = 1'b1;
      bus_a.address = addr;
   endtask

   task automatic wr_a(input logic [2:0] addr, input logic [31:0] d, input logic [3:0] be);
      bus_a.write      = 1'b1;
      bus_a.address    = addr;
      bus_a.writedata  = d;
      bus_a.byteenable = be;
   endtask

   task automatic idle_a();
      bus_a.read  = 1'b0;
      bus_a.write = 1'b0;
   endtask

   task automatic reset_a();
      rst_a = 1'b1;
      steps(2);
      chk_a("rst_a", 1'b0, 32'd0);
      rst_a = 1'b0;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst_a = 1'b1;
      rst_b = 1'b1;
      bus_a.address = 3'd0; bus_a.read = 1'b0; bus_a.write = 1'b0;
      bus_a.writedata = 32'd0; bus_a.byteenable = 4'd0;
      bus_b.address = 3'd0; bus_b.read = 1'b0; bus_b.write = 1'b0;
      bus_b.writedata = 32'd0; bus_b.byteenable = 4'd0;
      @(negedge clk);
      reset_a();

      // Back-to-back reads of ID, TS, CAPS, 7 with latency 2
      rd_a(3'd0); step();
      chk_a("id_early", 1'b0, 32'd0);
      rd_a(3'd1); step();
      chk_a("id", 1'b1, 32'h5799_0A3F);
      rd_a(3'd6); step();
      chk_a("ts", 1'b1, 32'h1234_5678);
      rd_a(3'd7); step();
      chk_a("caps", 1'b1, 32'h0001_0200);
      idle_a(); step();
      chk_a("addr7", 1'b1, 32'd0);
      step();
      chk_a("idle", 1'b0, 32'd0);

      // Uptime after release, then SECONDS after 35 cycles
      reset_a();
      step();
      rd_a(3'd2); step();
      idle_a(); step();
      chk_a("uptime_first", 1'b1, 32'd1);
      steps(32);
      rd_a(3'd4); step();
      idle_a(); step();
      chk_a("seconds_35", 1'b1, 32'd3);

      // Clear coinciding with terminal count at edge 10
      reset_a();
      steps(9);
      wr_a(3'd4, 32'hFFFF_FFFF, 4'hF); step();
      idle_a(); rd_a(3'd4); step();
      idle_a(); step();
      chk_a("sec_clear", 1'b1, 32'd0);
      steps(7);
      rd_a(3'd4); step();
      step();
      chk_a("sec_pre_inc", 1'b1, 32'd0);
      idle_a(); step();
      chk_a("sec_inc", 1'b1, 32'd1);

      // Scratch byte lanes and RO write
      wr_a(3'd5, 32'hAABB_CCDD, 4'b0101); step();
      idle_a(); rd_a(3'd5); step();
      idle_a(); step();
      chk_a("scratch_be", 1'b1, 32'h00BB_00DD);
      wr_a(3'd0, 32'hFFFF_FFFF, 4'hF); step();
      idle_a(); rd_a(3'd0); step();
      idle_a(); step();
      chk_a("id_ro", 1'b1, 32'h5799_0A3F);

      // Same-cycle read and write of scratch
      wr_a(3'd5, 32'd1, 4'hF); step();
      wr_a(3'd5, 32'd2, 4'hF); bus_a.read = 1'b1; step();
      bus_a.write = 1'b0; step();
      bus_a.read = 1'b0;
      chk_a("rw_old", 1'b1, 32'd1);
      step();
      chk_a("rw_new", 1'b1, 32'd2);

      // Coherent 64-bit snapshot
      force dut_a.r_uptime = 64'h0000_0001_FFFF_FFFE;
      rd_a(3'd2); step();
      release dut_a.r_uptime;
      idle_a(); step();
      chk_a("up_lo", 1'b1, 32'hFFFF_FFFE);
      steps(3);
      rd_a(3'd3); step();
      idle_a(); step();
      chk_a("up_hi", 1'b1, 32'h0000_0001);

      // DUT B: latency 3 CAPS read
      rst_b = 1'b0;
      bus_b.read = 1'b1; bus_b.address = 3'd6; step();
      bus_b.read = 1'b0;
      chk("b_lat1_vld", {31'd0, bus_b.readdatavalid}, 32'd0);
      step();
      chk("b_lat2_vld", {31'd0, bus_b.readdatavalid}, 32'd0);
      step();
      chk("b_caps_vld", {31'd0, bus_b.readdatavalid}, 32'd1);
      chk("b_caps", bus_b.readdata, 32'h0001_0300);

      // DUT B: reset one cycle after a read is issued
      step();
      bus_b.read = 1'b1; bus_b.address = 3'd0; step();
      bus_b.read = 1'b0; rst_b = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("b_rst_vld", {31'd0, bus_b.readdatavalid}, 32'd0);
         chk("b_rst_data", bus_b.readdata, 32'd0);
      end
      rst_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("b_post_vld", {31'd0, bus_b.readdatavalid}, 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/qsys_sysid_ext.md
# qsys_sysid_ext

Parametrised system-identification slave for the QSys fabric. It extends the fixed ID/timestamp word pair with:
- a free-running 64-bit uptime counter with a coherent high-word snapshot;
- a seconds counter driven by a prescaler;
- a software scratch register;
- a capability word.

Reads return data after a configurable pipelined latency with `readdatavalid`. Firmware uses the block to identify the image, measure elapsed time and check that the bus is alive.

## Interface
- `SYS_ID`, 32'h0000_0000: system ID word returned at address 0.
- `TIMESTAMP`, 32'h0000_0000: build timestamp returned at address 1.
- `CLK_HZ`, 50_000_000: clock frequency and prescaler terminal count. Legal range is 2..2^32-1.
- `READ_LATENCY`, 1: cycles from the read request to `readdatavalid`. Legal range is 1..3.
- `SCRATCH_INIT`, 32'h0000_0000: reset value of the scratch register.

Ports:
- `clock` in 1: sole clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `address` in 3: word address.
- `read` in 1: read request, accepted every cycle it is high.
- `write` in 1: write request.
- `writedata` in 32: write data.
- `byteenable` in 4: byte lanes for writes.
- `readdata` out 32: read data, valid only while `readdatavalid` is high.
- `readdatavalid` out 1: one-cycle pulse per accepted read.

## Operation
Register map (word addresses):
- 0 ID (RO): `SYS_ID`.
- 1 TS (RO): `TIMESTAMP`.
- 2 UP_LO (RO): `uptime[31:0]`. Reading it also loads `uptime[63:32]` into `up_shadow` in the same cycle.
- 3 UP_HI (RO): `up_shadow`.
- 4 SECONDS (RW): seconds since reset or since the last clear. Any write clears it; write data and byteenables are ignored.
- 5 SCRATCH (RW): byte-lane write using `byteenable`.
- 6 CAPS (RO): `{16'h0001, 6'b0, READ_LATENCY[1:0], 8'd0}`. Bits [31:16] are the version field.
- 7: reads 0. Writes are ignored.

Writes to RO addresses have no effect.

Uptime counter:
- 64-bit; increments every cycle out of reset.
- Wraps from 2^64-1 to 0.

Seconds counter:
- A 32-bit prescaler counts 0..CLK_HZ-1.
- On the terminal count the prescaler returns to 0 and `seconds` increments, wrapping at 2^32.
- A write to address 4 sets both the prescaler and `seconds` to 0. The clear wins over a same-cycle terminal count.

Read path:
- Data is sampled in the cycle `read` is high, not when it is returned.
- Data goes through a `READ_LATENCY`-deep shift pipeline of {valid, data}.
- Full throughput: one read per cycle with no stalls and no waitrequest.

Simultaneous `read` and `write`:
- Both are performed.
- The read returns the value as it was before the write.

## Timing
- Reset values: `readdata` = 0, `readdatavalid` = 0, `uptime` = 0, `up_shadow` = 0, prescaler = 0, `seconds` = 0, scratch = `SCRATCH_INIT`. All read-pipeline stages are cleared.
- The first clock after `reset` deasserts produces `uptime` = 1.
- A read accepted at edge N gives `readdatavalid` = 1 and `readdata` during the cycle after edge N+`READ_LATENCY`-1. With latency 1, data appears in the cycle following the request.
- A read of UP_LO at edge N returns `uptime` as held before edge N. `up_shadow` holds the matching high word from edge N onward, so an UP_HI read at any later edge returns it.
- A write at edge N is visible to a read accepted at edge N+1.
- `readdata` holds 0 when `readdatavalid` is low.
- Reset asserted mid-read: all in-flight reads are discarded and no `readdatavalid` pulse appears after reset.
- The first `seconds` increment occurs CLK_HZ cycles after reset release.

## Test plan
- Post-reset reads with `SYS_ID`=32'h5799_0A3F, `TIMESTAMP`=32'h1234_5678 and `READ_LATENCY`=2: read addresses 0, 1, 6 and 7 back-to-back. Expect valid pulses 2 cycles after each request, in order, with data 32'h5799_0A3F, 32'h1234_5678, 32'h0001_0200 and 0.
- Coherent 64-bit snapshot: force `uptime` to 64'h0000_0001_FFFF_FFFE, read UP_LO, then read UP_HI 5 cycles later. Expect 32'hFFFF_FFFE, then 32'h0000_0001, even though the live high word has become 2.
- Seconds counter with `CLK_HZ`=10:
  - After 35 cycles, SECONDS reads 3.
  - Write address 4 in the same cycle as the prescaler terminal count: the following read returns 0, and the next increment comes 10 cycles after the write.
- Scratch byte lanes: write 32'hAABB_CCDD with byteenable 4'b0101 over `SCRATCH_INIT`=0, then read. Expect 32'h00BB_00DD. A write to address 0 leaves ID unchanged.
- Same-cycle read/write: scratch holds 1, then read and write 2 to address 5 in one cycle. That read returns 1; the next read returns 2.
- Reset mid-read with `READ_LATENCY`=3: issue a read, then assert `reset` 1 cycle later. No `readdatavalid` appears, and all outputs are 0 during reset.
